// File: rtl/filter_pkg.sv
// Shared types and helpers for the window-filter sequencer.
package filter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    localparam int COORD_W = 16;

    // Sideband travelling alongside the filter pipeline.
    typedef struct packed {
        logic               valid;
        logic               sof;
        logic               eol;
        logic               border;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } sideband_t;

    localparam int SB_W = $bits(sideband_t);

    // Shifts between a pixel entering the filter and the window centred on it:
    // R full rows plus R pixels, with R the window half-size.
    function automatic int calc_latency(input int n, input int w);
        return (n / 2) * w + (n / 2);
    endfunction

endpackage

// File: rtl/sideband_delay.sv
// Fixed-depth delay line that keeps the sideband aligned with the filter output.
module sideband_delay
    import filter_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [SB_W-1:0] din,
    output logic [SB_W-1:0] dout
);

    logic [SB_W-1:0] pipe [DEPTH];

    // Advance one stage per cycle; a flush drops entries already in flight but
    // still loads the entry produced in the flushing cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= flush ? '0 : pipe[i-1];
        end
    end

    assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/filter_ctrl.sv
// Sequencer for an NxN window filter: feeds the raster stream, zero-pads the
// tail so the row buffers drain, and emits a sideband aligned with data_out.
module filter_ctrl
    import filter_pkg::*;
#(
    parameter int N          = 3,
    parameter int DATA_WIDTH = 26,
    parameter int LINE_WIDTH = 5,
    parameter int ROW_NUMBER = 5,
    parameter int FLT_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sof,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  flt_en,
    output logic [DATA_WIDTH-1:0] flt_data,
    output logic                  out_valid,
    output logic                  out_sof,
    output logic                  out_eol,
    output logic                  out_border,
    output logic [15:0]           out_x,
    output logic [15:0]           out_y,
    output logic                  sof_err
);

    localparam int          R          = N / 2;
    localparam int          D          = calc_latency(N, LINE_WIDTH);
    localparam logic [31:0] LAST_PIX   = 32'(LINE_WIDTH * ROW_NUMBER - 1);
    localparam logic [31:0] LAST_SHIFT = 32'(LINE_WIDTH * ROW_NUMBER + D - 1);
    localparam logic [15:0] X_LAST     = 16'(LINE_WIDTH - 1);
    localparam logic [15:0] Y_LAST     = 16'(ROW_NUMBER - 1);
    localparam state_t      END_ST     = (D > 0) ? DRAIN : IDLE;

    if (N < 1 || (N % 2) == 0) begin : g_bad_n
        $error("filter_ctrl: N must be odd and >= 1");
    end
    if (LINE_WIDTH < N || LINE_WIDTH > 65535) begin : g_bad_w
        $error("filter_ctrl: LINE_WIDTH must be in N..65535");
    end
    if (ROW_NUMBER < N || ROW_NUMBER > 65535) begin : g_bad_h
        $error("filter_ctrl: ROW_NUMBER must be in N..65535");
    end
    if (FLT_LAT < 1) begin : g_bad_lat
        $error("filter_ctrl: FLT_LAT must be >= 1");
    end

    state_t      state, state_nxt;
    logic [31:0] s_cnt;
    logic [15:0] ox, oy;
    logic        start, abort, bad_sof, shift, produce, lat_ok, border_c;
    logic [31:0] cur_s;
    logic [15:0] cur_x, cur_y;
    sideband_t   sb_in, sb_out;

    // An accepted SOF restarts the frame: this pixel is shift 0 at (0,0).
    assign start = in_valid && in_sof && (state != DRAIN);
    assign cur_s = start ? '0 : s_cnt;
    assign cur_x = start ? '0 : ox;
    assign cur_y = start ? '0 : oy;

    if (D == 0) begin : g_no_lat
        assign lat_ok = 1'b1;
    end else begin : g_lat
        assign lat_ok = (cur_s >= 32'(D));
    end

    if (R == 0) begin : g_no_border
        assign border_c = 1'b0;
    end else begin : g_border
        assign border_c = (cur_x < 16'(R)) || (cur_x >= 16'(LINE_WIDTH - R)) ||
                          (cur_y < 16'(R)) || (cur_y >= 16'(ROW_NUMBER - R));
    end

    // Next state, handshake and shift enable; shifting is suppressed in reset.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b1;
        shift     = 1'b0;
        abort     = 1'b0;
        bad_sof   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    shift     = 1'b1;
                    state_nxt = (cur_s == LAST_PIX) ? END_ST : ACTIVE;
                end else if (in_valid) begin
                    bad_sof = 1'b1;
                end
            end
            ACTIVE: begin
                if (in_valid) begin
                    shift     = 1'b1;
                    abort     = in_sof;
                    state_nxt = (cur_s == LAST_PIX) ? END_ST : ACTIVE;
                end
            end
            DRAIN: begin
                in_ready = 1'b0;
                shift    = 1'b1;
                if (s_cnt == LAST_SHIFT) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (!rst) shift = 1'b0;
    end

    assign flt_en   = shift;
    assign flt_data = (shift && state != DRAIN) ? in_data : '0;
    assign produce  = shift && lat_ok;

    // Sideband for the output produced by this shift; zero when nothing is produced.
    always_comb begin
        sb_in = '0;
        if (produce) begin
            sb_in.valid  = 1'b1;
            sb_in.sof    = (cur_x == '0) && (cur_y == '0);
            sb_in.eol    = (cur_x == X_LAST);
            sb_in.border = border_c;
            sb_in.x      = cur_x;
            sb_in.y      = cur_y;
        end
    end

    // State, shift counter and wrapping output coordinates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            s_cnt   <= '0;
            ox      <= '0;
            oy      <= '0;
            sof_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            sof_err <= abort || bad_sof;
            if (shift) begin
                s_cnt <= cur_s + 32'd1;
                if (produce) begin
                    if (cur_x == X_LAST) begin
                        ox <= '0;
                        oy <= (cur_y == Y_LAST) ? '0 : cur_y + 16'd1;
                    end else begin
                        ox <= cur_x + 16'd1;
                        oy <= cur_y;
                    end
                end else begin
                    ox <= cur_x;
                    oy <= cur_y;
                end
            end
        end
    end

    sideband_delay #(.DEPTH(FLT_LAT)) u_sb (
        .clk   (clk),
        .rst   (rst),
        .flush (abort),
        .din   (sb_in),
        .dout  (sb_out)
    );

    assign out_valid  = sb_out.valid;
    assign out_sof    = sb_out.sof;
    assign out_eol    = sb_out.eol;
    assign out_border = sb_out.border;
    assign out_x      = sb_out.x;
    assign out_y      = sb_out.y;

endmodule
